// File: rtl/i2c_seq_pkg.sv
// Shared opcodes, state encoding and constants for the I2C register sequencer.
package i2c_seq_pkg;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_ACK  = 3'd3;
  localparam logic [2:0] CMD_READ_NACK = 3'd4;
  localparam logic [2:0] CMD_STOP      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_W,
    ST_REG,
    ST_DATA_W,
    ST_RSTART,
    ST_DATA_R,
    ST_STOP,
    ST_FIN
  } state_t;

  // Read data reported when a read transaction ends in error.
  localparam logic [7:0] ERR_RDATA = 8'hFF;

  // Address byte sent after a (repeated) START: 7-bit address plus R/W bit.
  function automatic logic [7:0] addrByte(input logic [6:0] dev, input logic rd);
    return {dev, rd};
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// winner and wraps, so every requester is served within NREQ grants.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o,
  output logic [NREQ-1:0] onehot_o
);

  // Walk offsets from farthest to nearest so the nearest pending requester after last_i wins.
  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int off = NREQ; off >= 1; off--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req_i[j] && (((int'(last_i) + off) % NREQ) == j)) begin
          valid_o     = 1'b1;
          idx_o       = IW'(j);
          onehot_o    = '0;
          onehot_o[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Sequences arbitrated register read/write requests into I2C byte-master
// commands: START/addr, register pointer, data or repeated START + read, STOP.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_dev,
  input  logic [8*NREQ-1:0] req_reg,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [7:0]        cmd_data,
  input  logic              rsp_valid,
  input  logic              rsp_ack,
  input  logic [7:0]        rsp_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  state_t          state_q;
  logic [IW-1:0]   lastGrant_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q, wdata_q, rbuf_q;
  logic            rw_q;
  logic            cmdValid_q, waitRsp_q;
  logic [2:0]      cmdOp_q;
  logic [7:0]      cmdData_q;
  logic [TW-1:0]   tmo_q;
  logic            errFlag_q, err_q, busy_q;
  logic [7:0]      rdata_q;
  logic [NREQ-1:0] reqReady_q, done_q;

  logic            gntValid;
  logic [IW-1:0]   gntIdx;
  logic [NREQ-1:0] gntOneHot, ownerOneHot;
  logic [6:0]      selDev;
  logic [7:0]      selReg, selWdata;
  logic            selRw;
  logic [2:0]      issueOp;
  logic [7:0]      issueData;
  state_t          rspNext;
  logic            rspErr, tmoHit;

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .req_i    (req_valid),
    .last_i   (lastGrant_q),
    .valid_o  (gntValid),
    .idx_o    (gntIdx),
    .onehot_o (gntOneHot)
  );

  // Pick the winning requester's fields so they can be latched at grant.
  always_comb begin
    selDev   = '0;
    selReg   = '0;
    selWdata = '0;
    selRw    = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (gntIdx == IW'(j)) begin
        selDev   = req_dev[j*7 +: 7];
        selReg   = req_reg[j*8 +: 8];
        selWdata = req_wdata[j*8 +: 8];
        selRw    = req_rw[j];
      end
    end
  end

  // Per-state command to issue and where a completed response leads.
  always_comb begin
    issueOp   = CMD_NOP;
    issueData = '0;
    rspNext   = ST_STOP;
    rspErr    = 1'b0;
    case (state_q)
      ST_ADDR_W: begin
        issueOp   = CMD_START;
        issueData = addrByte(dev_q, 1'b0);
        rspNext   = rsp_ack ? ST_REG : ST_STOP;
        rspErr    = !rsp_ack;
      end
      ST_REG: begin
        issueOp   = CMD_WRITE;
        issueData = reg_q;
        rspNext   = !rsp_ack ? ST_STOP : (rw_q ? ST_RSTART : ST_DATA_W);
        rspErr    = !rsp_ack;
      end
      ST_DATA_W: begin
        issueOp   = CMD_WRITE;
        issueData = wdata_q;
        rspNext   = ST_STOP;
        rspErr    = !rsp_ack;
      end
      ST_RSTART: begin
        issueOp   = CMD_START;
        issueData = addrByte(dev_q, 1'b1);
        rspNext   = rsp_ack ? ST_DATA_R : ST_STOP;
        rspErr    = !rsp_ack;
      end
      ST_DATA_R: begin
        issueOp   = CMD_READ_NACK;
        rspNext   = ST_STOP;
      end
      ST_STOP: begin
        issueOp   = CMD_STOP;
        rspNext   = ST_FIN;
      end
      default: ;
    endcase
  end

  assign tmoHit      = (tmo_q == TMO_MAX);
  assign ownerOneHot = NREQ'(1) << lastGrant_q;

  // Main sequencer: grant, issue one command per state, await handshake then response, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= IW'(NREQ - 1);
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      rbuf_q      <= '0;
      cmdValid_q  <= 1'b0;
      waitRsp_q   <= 1'b0;
      cmdOp_q     <= CMD_NOP;
      cmdData_q   <= '0;
      tmo_q       <= '0;
      errFlag_q   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      reqReady_q  <= '0;
      done_q      <= '0;
    end else begin
      reqReady_q <= '0;
      done_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gntValid) begin
            reqReady_q  <= gntOneHot;
            lastGrant_q <= gntIdx;
            dev_q       <= selDev;
            reg_q       <= selReg;
            wdata_q     <= selWdata;
            rw_q        <= selRw;
            busy_q      <= 1'b1;
            errFlag_q   <= 1'b0;
            tmo_q       <= '0;
            state_q     <= ST_ADDR_W;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          if (!cmdValid_q && !waitRsp_q) begin
            cmdValid_q <= 1'b1;
            cmdOp_q    <= issueOp;
            cmdData_q  <= issueData;
          end else if (cmdValid_q) begin
            if (cmd_ready) begin
              cmdValid_q <= 1'b0;
              waitRsp_q  <= 1'b1;
            end else if (tmoHit) begin
              cmdValid_q <= 1'b0;
              errFlag_q  <= 1'b1;
              tmo_q      <= '0;
              if (state_q == ST_STOP) begin
                state_q <= ST_FIN;
                done_q  <= ownerOneHot;
                err_q   <= 1'b1;
                if (rw_q) rdata_q <= ERR_RDATA;
              end else begin
                state_q <= ST_STOP;
              end
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end else begin
            if (rsp_valid) begin
              waitRsp_q <= 1'b0;
              tmo_q     <= '0;
              state_q   <= rspNext;
              if (rspErr) errFlag_q <= 1'b1;
              if (state_q == ST_DATA_R) rbuf_q <= rsp_data;
              if (state_q == ST_STOP) begin
                done_q <= ownerOneHot;
                err_q  <= errFlag_q;
                if (rw_q) rdata_q <= errFlag_q ? ERR_RDATA : rbuf_q;
              end
            end else if (tmoHit) begin
              waitRsp_q <= 1'b0;
              errFlag_q <= 1'b1;
              tmo_q     <= '0;
              if (state_q == ST_STOP) begin
                state_q <= ST_FIN;
                done_q  <= ownerOneHot;
                err_q   <= 1'b1;
                if (rw_q) rdata_q <= ERR_RDATA;
              end else begin
                state_q <= ST_STOP;
              end
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
        end
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign cmd_valid = cmdValid_q;
  assign cmd_op    = cmdOp_q;
  assign cmd_data  = cmdData_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: a table of complete transactions with
// hand-computed command streams, plus arbitration, timeout and reset sequences.
module tb_i2c_reg_sequencer;
  import i2c_seq_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_rw, done;
  logic [7*NREQ-1:0] req_dev;
  logic [8*NREQ-1:0] req_reg, req_wdata;
  logic              err, busy, cmd_valid, cmd_ready, rsp_valid, rsp_ack;
  logic [7:0]        rdata, cmd_data, rsp_data;
  logic [2:0]        cmd_op;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    int               r;
    logic             rw;
    logic [6:0]       dev;
    logic [7:0]       regA;
    logic [7:0]       wdata;
    int               nCmd;
    logic [5:0][2:0]  ops;
    logic [5:0][7:0]  data;
    logic [5:0]       ack;
    logic [7:0]       rspData;
    logic             expErr;
    logic [7:0]       expRdata;
  } vec_t;

  vec_t tbl [6];
  vec_t vArb0, vArb1, vTmo, vRst;

  i2c_reg_sequencer #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_dev   (req_dev),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ack   (rsp_ack),
    .rsp_data  (rsp_data)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic vec_t mk(int r, logic rw, logic [6:0] dev, logic [7:0] ra, logic [7:0] wd,
                              int n, logic [5:0][2:0] ops, logic [5:0][7:0] dat, logic [5:0] ack,
                              logic [7:0] rd, logic e, logic [7:0] erd);
    vec_t v;
    v.r = r; v.rw = rw; v.dev = dev; v.regA = ra; v.wdata = wd; v.nCmd = n;
    v.ops = ops; v.data = dat; v.ack = ack; v.rspData = rd; v.expErr = e; v.expRdata = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic setReq(input vec_t v);
    req_rw[v.r]             = v.rw;
    req_dev[v.r*7 +: 7]     = v.dev;
    req_reg[v.r*8 +: 8]     = v.regA;
    req_wdata[v.r*8 +: 8]   = v.wdata;
    req_valid[v.r]          = 1'b1;
  endtask

  task automatic waitGrant(input logic [NREQ-1:0] exp, input string nm);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(|req_ready) && w < 30);
    check({nm, "_req_ready"}, 32'(req_ready), 32'(exp));
    check({nm, "_busy_at_grant"}, 32'(busy), 32'd1);
    req_valid = req_valid & ~req_ready;
  endtask

  task automatic serveCmd(input logic [2:0] op, input logic [7:0] dat, input logic ack,
                          input logic [7:0] rd, input bit sendRsp, input string nm);
    int w = 0;
    while (!cmd_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_cmd_seen"}, 32'(cmd_valid), 32'd1);
    check({nm, "_op"}, 32'(cmd_op), 32'(op));
    if (op == CMD_START || op == CMD_WRITE)
      check({nm, "_data"}, 32'(cmd_data), 32'(dat));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check({nm, "_cmd_drop"}, 32'(cmd_valid), 32'd0);
    if (sendRsp) begin
      @(negedge clk);
      rsp_valid = 1'b1;
      rsp_ack   = ack;
      rsp_data  = rd;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_ack   = 1'b0;
      rsp_data  = 8'h00;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string nm);
    for (int k = 0; k < v.nCmd; k++)
      serveCmd(v.ops[k], v.data[k], v.ack[k], v.rspData, 1'b1, $sformatf("%s_c%0d", nm, k));
  endtask

  task automatic checkOutput(input vec_t v, input string nm);
    logic [NREQ-1:0] oh;
    int w = 0;
    oh = '0;
    oh[v.r] = 1'b1;
    while (!(|done) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_done"}, 32'(done), 32'(oh));
    check({nm, "_err"}, 32'(err), 32'(v.expErr));
    check({nm, "_rdata"}, 32'(rdata), 32'(v.expRdata));
    check({nm, "_busy_fin"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({nm, "_busy_idle"}, 32'(busy), 32'd0);
    check({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic checkResetOutputs(input string nm);
    check({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    check({nm, "_done"}, 32'(done), 32'd0);
    check({nm, "_err"}, 32'(err), 32'd0);
    check({nm, "_rdata"}, 32'(rdata), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({nm, "_cmd_op"}, 32'(cmd_op), 32'd0);
    check({nm, "_cmd_data"}, 32'(cmd_data), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [2:0] stopOp;
    logic [2:0] rdOp;

    stopOp = CMD_STOP;
    rdOp   = CMD_READ_NACK;
    // Write: START {dev,0}, WRITE reg, WRITE data, STOP.
    tbl[0] = mk(0, 1'b0, 7'h4B, 8'h02, 8'h5A, 4,
                {3'd0, 3'd0, CMD_STOP, CMD_WRITE, CMD_WRITE, CMD_START},
                {8'h00, 8'h00, 8'h00, 8'h5A, 8'h02, 8'h96}, 6'b111111, 8'h00, 1'b0, 8'h00);
    // Read: START 96, WRITE reg, START 97, READ_NACK, STOP.
    tbl[1] = mk(1, 1'b1, 7'h4B, 8'h00, 8'h00, 5,
                {3'd0, CMD_STOP, CMD_READ_NACK, CMD_START, CMD_WRITE, CMD_START},
                {8'h00, 8'h00, 8'h00, 8'h97, 8'h00, 8'h96}, 6'b111111, 8'hAA, 1'b0, 8'hAA);
    // Register byte NACKed: STOP follows directly, rdata keeps the last read.
    tbl[2] = mk(0, 1'b0, 7'h4B, 8'h20, 8'h11, 3,
                {3'd0, 3'd0, 3'd0, CMD_STOP, CMD_WRITE, CMD_START},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h96}, 6'b111101, 8'h00, 1'b1, 8'hAA);
    tbl[3] = mk(1, 1'b0, 7'h2C, 8'h7F, 8'hC3, 4,
                {3'd0, 3'd0, CMD_STOP, CMD_WRITE, CMD_WRITE, CMD_START},
                {8'h00, 8'h00, 8'h00, 8'hC3, 8'h7F, 8'h58}, 6'b111111, 8'h00, 1'b0, 8'hAA);
    tbl[4] = mk(0, 1'b1, 7'h4B, 8'h05, 8'h00, 5,
                {3'd0, CMD_STOP, CMD_READ_NACK, CMD_START, CMD_WRITE, CMD_START},
                {8'h00, 8'h00, 8'h00, 8'h97, 8'h05, 8'h96}, 6'b111111, 8'h3C, 1'b0, 8'h3C);
    // Repeated-START address NACKed on a read: error, rdata forced to FF.
    tbl[5] = mk(1, 1'b1, 7'h4B, 8'h05, 8'h00, 4,
                {3'd0, 3'd0, CMD_STOP, CMD_START, CMD_WRITE, CMD_START},
                {8'h00, 8'h00, 8'h00, 8'h97, 8'h05, 8'h96}, 6'b111011, 8'h00, 1'b1, 8'hFF);
    vArb0 = tbl[0];
    vArb1 = tbl[0];
    vArb1.r = 1;
    vTmo = mk(0, 1'b1, 7'h4B, 8'h00, 8'h00, 0, '0, '0, '0, 8'h00, 1'b1, 8'hFF);
    vRst = mk(1, 1'b1, 7'h4B, 8'h00, 8'h00, 0, '0, '0, '0, 8'h00, 1'b0, 8'h00);

    rst_n = 1'b0; req_valid = '0; req_rw = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_ack = 1'b0; rsp_data = 8'h00;
    repeat (3) @(negedge clk);
    checkResetOutputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("rst_rel");

    // Arbitration: both request together, requester 0 first; then rotate fairly.
    setReq(vArb0); setReq(vArb1);
    waitGrant(2'b01, "arb1_g0");
    applyStimulus(vArb0, "arb1_t0"); checkOutput(vArb0, "arb1_t0");
    waitGrant(2'b10, "arb1_g1");
    applyStimulus(vArb1, "arb1_t1"); checkOutput(vArb1, "arb1_t1");
    setReq(vArb0); setReq(vArb1);
    waitGrant(2'b01, "arb2_g0");
    applyStimulus(vArb0, "arb2_t0"); checkOutput(vArb0, "arb2_t0");
    waitGrant(2'b10, "arb2_g1");
    applyStimulus(vArb1, "arb2_t1"); checkOutput(vArb1, "arb2_t1");

    for (int i = 0; i < 6; i++) begin
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[tbl[i].r] = 1'b1;
      setReq(tbl[i]);
      waitGrant(oh, $sformatf("v%0d", i));
      applyStimulus(tbl[i], $sformatf("v%0d", i));
      checkOutput(tbl[i], $sformatf("v%0d", i));
    end

    // Timeout: START accepted but never answered.
    setReq(vTmo);
    waitGrant(2'b01, "tmo");
    serveCmd(CMD_START, 8'h96, 1'b1, 8'h00, 1'b0, "tmo_start");
    cyc = 0;
    while (!cmd_valid && cyc < TMO + 50) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_latency_in_range", 32'((cyc >= TMO) && (cyc <= TMO + 6)), 32'd1);
    serveCmd(stopOp, 8'h00, 1'b1, 8'h00, 1'b1, "tmo_stop");
    checkOutput(vTmo, "tmo");

    // Reset during DATA_R: everything returns to reset values immediately.
    setReq(vRst);
    waitGrant(2'b10, "rstmid");
    serveCmd(CMD_START, 8'h96, 1'b1, 8'h00, 1'b1, "rstmid_c0");
    serveCmd(CMD_WRITE, 8'h00, 1'b1, 8'h00, 1'b1, "rstmid_c1");
    serveCmd(CMD_START, 8'h97, 1'b1, 8'h00, 1'b1, "rstmid_c2");
    serveCmd(rdOp, 8'h00, 1'b1, 8'h00, 1'b0, "rstmid_c3");
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    setReq(vArb0); setReq(vArb1);
    waitGrant(2'b01, "post_g0");
    applyStimulus(vArb0, "post_t0"); checkOutput(vArb0, "post_t0");
    waitGrant(2'b10, "post_g1");
    applyStimulus(vArb1, "post_t1"); checkOutput(vArb1, "post_t1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Arbitrates register-access requests from NREQ local requesters and sequences each one as a complete I2C register transaction on a shared byte-level I2C master. Supported transactions are a register write, or a register read using a repeated start. The block sits between on-chip clients and the bit/byte master core. It drives slaves of the kind modelled by our Pmod slave models, e.g. address 7'h4B with an 8-bit register pointer.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 1023, max cycles to wait for any byte-master response

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request pending
- req_ready  out  NREQ  one-hot, 1-cycle pulse: request accepted (granted)
- req_rw  in  NREQ  1 = read, 0 = write
- req_dev  in  7*NREQ  slave address per requester
- req_reg  in  8*NREQ  register address per requester
- req_wdata  in  8*NREQ  write data per requester
- done  out  NREQ  one-hot, 1-cycle pulse: granted transaction finished
- err  out  1  valid with done: NACK or timeout occurred
- rdata  out  8  read data, valid with done for read transactions
- busy  out  1  transaction in progress
- cmd_valid  out  1  command to byte master
- cmd_ready  in  1  byte master accepts command
- cmd_op  out  3  command opcode
- cmd_data  out  8  byte to transmit
- rsp_valid  in  1  byte master completed a command
- rsp_ack  in  1  slave ACKed the transmitted byte
- rsp_data  in  8  byte received by a READ command

## Operation
- States: IDLE, ADDR_W, REG, DATA_W, RSTART, DATA_R, STOP, FIN.
- Each non-IDLE, non-FIN state issues exactly one command, waits for the cmd handshake, then waits for rsp_valid.
- Write sequence: ADDR_W (START, {dev,0}) -> REG (WRITE, reg) -> DATA_W (WRITE, wdata) -> STOP -> FIN.
- Read sequence: ADDR_W -> REG -> RSTART (START, {dev,1}) -> DATA_R (READ_NACK; capture rsp_data) -> STOP -> FIN.
- rsp_ack=0 on any START or WRITE response sets the sticky error flag and jumps to STOP. The STOP is always issued, so the bus is released.
- Timeout: a counter is cleared on each state entry and runs while waiting for cmd_ready or rsp_valid. Reaching TIMEOUT sets the error flag and goes to STOP.
  - A timeout in STOP itself goes directly to FIN.
- FIN pulses done[g] with err and rdata, then returns to IDLE.
  - rdata holds the last captured value until the next read completes.
  - rdata after a failed read is 8'hFF.
- Arbitration (round-robin, in IDLE only): the search starts at last_grant+1 and wraps modulo NREQ.
  - The winner's dev/reg/wdata/rw are latched. req_ready[winner] pulses in the same cycle.
  - The latched fields are used for the whole transaction; later changes on req_* are ignored.
- Requesters keep req_valid high until their req_ready pulse. Requests arriving mid-transaction wait.

## Timing
- Reset values:
  - state=IDLE, last_grant=NREQ-1 (requester 0 has first priority).
  - cmd_valid=0, cmd_op=0, cmd_data=0, req_ready=0, done=0, err=0, rdata=8'h00, busy=0, timeout counter=0.
- Request to command: req_valid high in IDLE -> req_ready pulse at the next clk edge -> cmd_valid asserted the cycle after.
- cmd_valid, cmd_op and cmd_data are stable until cmd_valid && cmd_ready. cmd_valid deasserts the following cycle.
- At most one command is outstanding.
- rsp_valid is ignored when no command is pending.
- rsp_valid in the same cycle as the handshake is not legal from the master. It is ignored.
- FIN lasts 1 cycle. A new grant is possible the cycle after done, so back-to-back transactions have 1 idle cycle.
- busy is high from the grant cycle through the FIN cycle.
- rst_n low mid-transaction: immediate return to reset values; no STOP is issued. The byte master is reset by the same rst_n.

## Structure
- Package i2c_seq_pkg holds:
  - Opcodes: CMD_NOP=0, CMD_START=1, CMD_WRITE=2, CMD_READ_ACK=3, CMD_READ_NACK=4, CMD_STOP=5.
  - The state enum.
  - The ERR_RDATA constant (8'hFF).
- One sub-module, rr_arbiter: combinational round-robin grant from req vector and last_grant. It is parameterized by NREQ and reusable.
- The sequencer FSM, latch registers and timeout counter stay in i2c_reg_sequencer.

## Test plan
- Write: req0 writes 8'h5A to reg 8'h02 of dev 7'h4B, slave ACKs all -> commands START 8'h96, WRITE 8'h02, WRITE 8'h5A, STOP; done[0]=1, err=0.
- Read: req1 reads reg 8'h00 of 7'h4B, slave returns 8'hAA -> commands START 8'h96, WRITE 8'h00, START 8'h97, READ_NACK, STOP; done[1]=1, rdata=8'hAA, err=0.
- NACK: write to reg 8'h20, REG byte NACKed -> STOP issued next, no DATA_W; done=1, err=1.
- Arbitration: req0 and req1 asserted in the same cycle after reset -> req0 granted first, req1 second. Then both again -> req1 is not favoured over req0 in the second round; grants alternate.
- Timeout: byte master never asserts rsp_valid after START -> after TIMEOUT cycles STOP is issued; done=1, err=1, rdata=8'hFF on a read.
- Reset mid-read: rst_n low during DATA_R -> all outputs return to reset values; the next request is granted normally with req0 priority.
